// File: rtl/lc3b_types.sv
// Shared type definitions for the LC-3b datapath blocks.
package lc3b_types;

  // Memory access unit control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } mau_state_e;

  // Width of a memory access
  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_WORD = 1'b1
  } access_size_e;

  // Width of the timeout counter (covers TIMEOUT up to 65535)
  localparam int MAU_CNT_W = 16;

  // A word access must start on lane 0; byte accesses may use any lane
  function automatic logic mau_misaligned(input access_size_e size, input logic lane_nonzero);
    return (size == SZ_WORD) && lane_nonzero;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering: store replication/mask generation and load select/extend.
module mau_lane_align
  import lc3b_types::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [$clog2(DATA_W/8)-1:0] st_lane,
  input  access_size_e                st_size,
  input  logic [DATA_W-1:0]           st_data_i,
  output logic [DATA_W-1:0]           st_data_o,
  output logic [DATA_W/8-1:0]         st_mask_o,
  input  logic [$clog2(DATA_W/8)-1:0] ld_lane,
  input  access_size_e                ld_size,
  input  logic                        ld_signed,
  input  logic [DATA_W-1:0]           ld_data_i,
  output logic [DATA_W-1:0]           ld_data_o
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] ld_shift_s;
  logic [7:0]        ld_byte_s;

  // Store path: byte data goes on every lane, mask enables only the addressed lane
  always_comb begin
    if (st_size == SZ_WORD) begin
      st_data_o = st_data_i;
      st_mask_o = {LANES{1'b1}};
    end else begin
      st_data_o = {LANES{st_data_i[7:0]}};
      st_mask_o = LANES'(1'b1) << st_lane;
    end
  end

  // Load path: shift the addressed lane down to bit 0, then zero/sign extend bytes
  always_comb begin
    ld_shift_s = ld_data_i >> {ld_lane, 3'b000};
    ld_byte_s  = ld_shift_s[7:0];
    if (ld_size == SZ_WORD) begin
      ld_data_o = ld_data_i;
    end else if (ld_signed && ld_byte_s[7]) begin
      ld_data_o = {{(DATA_W-8){1'b1}}, ld_byte_s};
    end else begin
      ld_data_o = {{(DATA_W-8){1'b0}}, ld_byte_s};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR based load/store sequencer with alignment and timeout faults.
module mem_access_unit
  import lc3b_types::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [MAU_CNT_W-1:0] CNT_LIMIT = MAU_CNT_W'(TIMEOUT - 1);

  mau_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    mar_q, mar_d;
  logic [DATA_W-1:0]    mdr_q, mdr_d;
  logic                 wr_q, wr_d;
  access_size_e         size_q, size_d;
  logic                 sgn_q, sgn_d;
  logic [MAU_CNT_W-1:0] cnt_q, cnt_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [LANES-1:0]     wmask_q, wmask_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [DATA_W-1:0]    st_data_s;
  logic [LANES-1:0]     st_mask_s;
  logic [DATA_W-1:0]    ld_data_s;
  logic                 misaligned_s;

  mau_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .st_lane   (req_addr[LANE_W-1:0]),
    .st_size   (access_size_e'(req_size)),
    .st_data_i (req_wdata),
    .st_data_o (st_data_s),
    .st_mask_o (st_mask_s),
    .ld_lane   (mar_q[LANE_W-1:0]),
    .ld_size   (size_q),
    .ld_signed (sgn_q),
    .ld_data_i (mem_rdata),
    .ld_data_o (ld_data_s)
  );

  assign misaligned_s = mau_misaligned(access_size_e'(req_size),
                                       req_addr[LANE_W-1:0] != {LANE_W{1'b0}});

  // Next-state and next-output logic; strobes/done/err are pulses, everything else holds
  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    cnt_d       = cnt_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    wmask_d     = wmask_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mar_d  = req_addr;
          mdr_d  = st_data_s;
          wr_d   = req_write;
          size_d = access_size_e'(req_size);
          sgn_d  = req_signed;
          cnt_d  = {MAU_CNT_W{1'b0}};
          if (misaligned_s) begin
            state_d = ST_FAULT;
            wmask_d = {LANES{1'b0}};
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_read_d  = ~req_write;
            mem_write_d = req_write;
            wmask_d     = req_write ? st_mask_s : {LANES{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A response arriving on the final counted cycle still completes normally
        if (mem_resp) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (!wr_q) begin
            mdr_d   = mem_rdata;
            rdata_d = ld_data_s;
          end else begin
            mdr_d = mdr_q;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_FAULT;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + 16'd1;
          mem_read_d  = ~wr_q;
          mem_write_d = wr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mar_q       <= {ADDR_W{1'b0}};
      mdr_q       <= {DATA_W{1'b0}};
      wr_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      sgn_q       <= 1'b0;
      cnt_q       <= {MAU_CNT_W{1'b0}};
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wmask_q     <= {LANES{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      wmask_q     <= wmask_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wmask   = wmask_q;
  assign mem_address = mar_q;
  assign mem_wdata   = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized + directed bench for mem_access_unit (16-bit/TIMEOUT=4 and 32-bit/TIMEOUT=6 instances).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid, req_write, req_size, req_signed, mem_resp;
  logic [15:0] req_addr;
  logic [31:0] req_wdata, mem_rdata;

  logic        ready16, done16, err16, mrd16, mwr16;
  logic [15:0] rdata16, maddr16, mwdata16;
  logic [1:0]  wmask16;
  logic        ready32, done32, err32, mrd32, mwr32;
  logic [31:0] rdata32, mwdata32;
  logic [15:0] maddr32;
  logic [3:0]  wmask32;

  logic        v_ready, v_done, v_err, v_mrd, v_mwr;
  logic [31:0] v_rdata, v_mwdata;
  logic [15:0] v_maddr;
  logic [3:0]  v_wmask;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] last_rdata [2];

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(ready16),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata[15:0]), .done(done16), .err(err16),
    .rdata(rdata16), .mem_read(mrd16), .mem_write(mwr16), .mem_wmask(wmask16),
    .mem_address(maddr16), .mem_wdata(mwdata16), .mem_resp(mem_resp & ~sel),
    .mem_rdata(mem_rdata[15:0])
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(6)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(ready32),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done32), .err(err32),
    .rdata(rdata32), .mem_read(mrd32), .mem_write(mwr32), .mem_wmask(wmask32),
    .mem_address(maddr32), .mem_wdata(mwdata32), .mem_resp(mem_resp & sel),
    .mem_rdata(mem_rdata)
  );

  assign v_ready  = sel ? ready32 : ready16;
  assign v_done   = sel ? done32  : done16;
  assign v_err    = sel ? err32   : err16;
  assign v_mrd    = sel ? mrd32   : mrd16;
  assign v_mwr    = sel ? mwr32   : mwr16;
  assign v_rdata  = sel ? rdata32 : {16'h0000, rdata16};
  assign v_mwdata = sel ? mwdata32 : {16'h0000, mwdata16};
  assign v_maddr  = sel ? maddr32 : maddr16;
  assign v_wmask  = sel ? wmask32 : {2'b00, wmask16};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction on the selected instance; k = cycle of mem_resp (1-based), 0 = never
  task automatic run_txn(input logic s, input logic wr, input logic sz, input logic sg,
                         input logic [15:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int k);
    int          nl, lane, tmo, n_strobe;
    logic        mis, exp_err;
    logic [31:0] dmask, ew, emask, eload, b;
    nl    = s ? 4 : 2;
    tmo   = s ? 6 : 4;
    dmask = s ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    lane  = int'(a) % nl;
    mis   = sz && (lane != 0);
    if (sz) begin
      ew    = wd & dmask;
      emask = (32'd1 << nl) - 32'd1;
      eload = rd & dmask;
    end else begin
      ew = 32'd0;
      for (int i = 0; i < nl; i++) ew = ew | ({24'd0, wd[7:0]} << (8 * i));
      emask = 32'd1 << lane;
      b     = ((rd & dmask) >> (8 * lane)) & 32'h0000_00FF;
      eload = (sg && b[7]) ? ((b | 32'hFFFF_FF00) & dmask) : b;
    end
    n_strobe = (k == 0) ? tmo : k;
    exp_err  = (k == 0);

    @(negedge clk);
    sel = s; req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; mem_rdata = rd; mem_resp = 1'b0;
    #1;
    check_eq("ready_idle", v_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (mis) begin
      check_eq("mis_strobe", {v_mrd, v_mwr}, 2'b00);
      check_eq("mis_done", v_done, 1'b1);
      check_eq("mis_err", v_err, 1'b1);
      check_eq("mis_rdata", v_rdata, last_rdata[s]);
    end else begin
      for (int c = 1; c <= n_strobe; c++) begin
        check_eq("strobe_rd", v_mrd, !wr);
        check_eq("strobe_wr", v_mwr, wr);
        check_eq("mar", v_maddr, a);
        check_eq("done_early", v_done, 1'b0);
        check_eq("ready_busy", v_ready, 1'b0);
        if (wr) begin
          check_eq("st_wdata", v_mwdata, ew);
          check_eq("st_wmask", v_wmask, emask);
        end
        mem_resp = (c == k);
        @(posedge clk); #1;
        mem_resp = 1'b0;
      end
      check_eq("end_strobe", {v_mrd, v_mwr}, 2'b00);
      check_eq("end_done", v_done, 1'b1);
      check_eq("end_err", v_err, exp_err);
      if (!wr && !exp_err) last_rdata[s] = eload;
      check_eq("rdata", v_rdata, last_rdata[s]);
    end
    @(posedge clk); #1;
    check_eq("done_pulse", v_done, 1'b0);
    check_eq("ready_back", v_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        s, wr, sz, sg;
    logic [15:0] a;
    int          k;

    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0;
    req_signed = 1'b0; req_addr = 16'h0000; req_wdata = 32'd0; mem_resp = 1'b0;
    mem_rdata = 32'd0;
    last_rdata[0] = 32'd0; last_rdata[1] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0]; #1;
      check_eq("rst_strobe", {v_mrd, v_mwr}, 2'b00);
      check_eq("rst_wmask", v_wmask, 4'h0);
      check_eq("rst_maddr", v_maddr, 16'h0000);
      check_eq("rst_mwdata", v_mwdata, 32'd0);
      check_eq("rst_rdata", v_rdata, 32'd0);
      check_eq("rst_done_err", {v_done, v_err}, 2'b00);
      check_eq("rst_ready", v_ready, 1'b1);
    end
    rst_n = 1'b1;

    // Directed cases
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 16'h1000, 32'd0, 32'h0000_BEEF, 3);
    check_eq("d_word_load", v_rdata, 32'h0000_BEEF);
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 16'h1001, 32'd0, 32'h0000_80AA, 2);
    check_eq("d_sbyte_load", v_rdata, 32'h0000_FF80);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h1001, 32'd0, 32'h0000_80AA, 1);
    check_eq("d_ubyte_load", v_rdata, 32'h0000_0080);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h2003, 32'h0000_005A, 32'd0, 3);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 32'd0, 32'h0000_1234, 1);
    check_eq("d_mis_hold", v_rdata, 32'h0000_0080);
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, 32'd0, 32'h0000_4321, 0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h0042, 32'h0000_A5C3, 32'd0, 4);
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 32'd0, 32'h12F3_5678, 6);
    check_eq("d_lane2_sext", v_rdata, 32'hFFFF_FFF3);

    // Reset while a load is in flight
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("mr_strobe_on", v_mrd, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mr_strobe_off", {v_mrd, v_mwr}, 2'b00);
    check_eq("mr_no_done", v_done, 1'b0);
    mem_resp = 1'b1; mem_rdata = 32'h0000_7777;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mr_no_done2", v_done, 1'b0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    check_eq("mr_no_done3", v_done, 1'b0);
    check_eq("mr_ready", v_ready, 1'b1);
    check_eq("mr_rdata", v_rdata, 32'd0);
    last_rdata[0] = 32'd0; last_rdata[1] = 32'd0;

    // Randomized transactions
    for (int n = 0; n < 80; n++) begin
      s  = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      sz = $urandom_range(0, 1);
      sg = $urandom_range(0, 1);
      a  = 16'($urandom);
      if (sz && ($urandom_range(0, 3) != 0)) a = a & (s ? 16'hFFFC : 16'hFFFE);
      k  = $urandom_range(0, s ? 6 : 4);
      run_txn(s, wr, sz, sg, a, $urandom, $urandom, k);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
